// File: rtl/muldiv_pkg.sv
// Shared types for the RV32M multiply/divide unit and the execute-stage ALU.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_e;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLL  = 4'h2;
  localparam logic [3:0] ALU_SLT  = 4'h3;
  localparam logic [3:0] ALU_SLTU = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_OR   = 4'h8;
  localparam logic [3:0] ALU_AND  = 4'h9;

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle between the execute stage and muldiv_unit.
interface muldiv_if #(parameter int W = 32);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;

  modport master (output in_valid, op, src_a, src_b, out_ready,
                  input  in_ready, out_valid, result);
  modport slave  (input  in_valid, op, src_a, src_b, out_ready,
                  output in_ready, out_valid, result);
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi,lo} pair: shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic         i_is_div,
  input  logic [W-1:0] i_hi,
  input  logic [W-1:0] i_lo,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  logic [W:0] w_sum, w_sh, w_diff;

  always_comb begin
    w_sum  = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
    w_sh   = {i_hi, i_lo[W-1]};
    w_diff = w_sh - {1'b0, i_b};
    if (i_is_div) begin
      // remainder < divisor keeps the shifted value below 2*divisor, so bit W is the borrow
      if (!w_diff[W]) begin
        o_hi = w_diff[W-1:0];
        o_lo = {i_lo[W-2:0], 1'b1};
      end else begin
        o_hi = w_sh[W-1:0];
        o_lo = {i_lo[W-2:0], 1'b0};
      end
    end else begin
      o_hi = w_sum[W:1];
      o_lo = {w_sum[0], i_lo[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Define MULDIV_FAST_MUL_EN for a single-cycle multiplier.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int W = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    flush,
  muldiv_if.slave bus
);

  localparam int            CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [W-1:0]  MINV = {1'b1, {(W-1){1'b0}}};

  mdu_state_e    r_state, w_next;
  mdu_op_e       r_op, w_op;
  logic          r_neg;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_hi, r_lo, r_b, r_result;
  logic          w_accept, w_last, w_short, w_neg_a, w_neg_b, w_neg;
  logic [W-1:0]  w_abs_a, w_abs_b, w_short_res, w_hi_n, w_lo_n, w_calc_res;
  logic [2*W-1:0] w_prod;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] w_fast, w_fast_s;
`endif

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;
  assign w_op          = mdu_op_e'(bus.op);
  assign w_accept      = bus.in_valid && (r_state == IDLE) && !flush;
  assign w_last        = (r_cnt == LAST);

  always_comb begin : accept_decode
    w_neg_a     = bus.src_a[W-1] && (w_op inside {MULH, MULHSU, DIV, REM});
    w_neg_b     = bus.src_b[W-1] && (w_op inside {MULH, DIV, REM});
    w_abs_a     = w_neg_a ? -bus.src_a : bus.src_a;
    w_abs_b     = w_neg_b ? -bus.src_b : bus.src_b;
    // remainder follows the dividend; everything else follows the sign product
    w_neg       = (w_op inside {REM, REMU}) ? w_neg_a : (w_neg_a ^ w_neg_b);
    w_short     = 1'b0;
    w_short_res = '0;
    if (w_op[2] && bus.src_b == '0) begin
      w_short     = 1'b1;
      w_short_res = w_op[1] ? bus.src_a : '1;
    end else if ((w_op inside {DIV, REM}) && bus.src_a == MINV && bus.src_b == '1) begin
      w_short     = 1'b1;
      w_short_res = w_op[1] ? '0 : bus.src_a;
    end
`ifdef MULDIV_FAST_MUL_EN
    w_fast   = {{W{1'b0}}, w_abs_a} * {{W{1'b0}}, w_abs_b};
    w_fast_s = w_neg ? -w_fast : w_fast;
    if (!w_op[2]) begin
      w_short     = 1'b1;
      w_short_res = (w_op == MUL) ? w_fast_s[W-1:0] : w_fast_s[2*W-1:W];
    end
`endif
  end

  muldiv_step #(.W(W)) u_step (
    .i_is_div (r_op[2]),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .i_b      (r_b),
    .o_hi     (w_hi_n),
    .o_lo     (w_lo_n)
  );

  // low half of a 2W negation equals the W-bit negation, so only REM needs its own
  always_comb begin : calc_result
    w_prod     = r_neg ? -{w_hi_n, w_lo_n} : {w_hi_n, w_lo_n};
    w_calc_res = w_prod[W-1:0];
    case (r_op)
      MULH, MULHSU, MULHU: w_calc_res = w_prod[2*W-1:W];
      REM, REMU:           w_calc_res = r_neg ? -w_hi_n : w_hi_n;
      default:             w_calc_res = w_prod[W-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin : next_state
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_short ? DONE : CALC;
      CALC:    if (flush) w_next = IDLE;
               else if (w_last) w_next = DONE;
      DONE:    if (flush || bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= MUL;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op  <= w_op;
      r_neg <= w_neg;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= w_abs_a;
      r_b   <= w_abs_b;
      if (w_short) r_result <= w_short_res;
    end else if (r_state == CALC && !flush) begin
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) r_result <= w_calc_res;
    end
  end

endmodule
